// File: rtl/action_merge_pipe_pkg.sv
`default_nettype none
//==============================================================================
// Module   : action_merge_pipe_pkg
// Brief    : Shared constants and helpers for the action merge pipeline stage.
// Revision : 1.0 - initial release
//==============================================================================
package action_merge_pipe_pkg;

   localparam int MERGE_OR   = 0;
   localparam int MERGE_PRIO = 1;

   localparam int C_ACT_LEN_DFLT      = 64;
   localparam int C_NUM_PHV_CONT_DFLT = 65;
   localparam int AW                  = C_ACT_LEN_DFLT * C_NUM_PHV_CONT_DFLT;

   // LSB of sub-unit 'unit' inside the flat action bus
   function automatic int act_lsb(input int unit, input int aw);
      return unit * aw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/action_merge_pipe_skid_fifo2.sv
`default_nettype none
//==============================================================================
// Module   : action_merge_pipe_skid_fifo2
// Brief    : Generic 2-entry valid/ready skid buffer with registered in_ready.
// Revision : 1.0 - initial release
//==============================================================================
module action_merge_pipe_skid_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             axis_clk,
   input  logic             aresetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             r_ready;
   logic [1:0]       w_count_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_push    = in_valid & r_ready;
   assign w_pop     = (r_count != 2'd0) & out_ready;
   assign in_ready  = r_ready;
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // in_ready is registered from the post-edge occupancy, so it never
   // combinationally follows out_ready
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
         end
         r_wr_ptr <= r_wr_ptr ^ w_push;
         r_rd_ptr <= r_rd_ptr ^ w_pop;
         r_count  <= w_count_nxt;
         r_ready  <= (w_count_nxt != 2'd2);
      end
   end

endmodule
`default_nettype wire

// File: rtl/action_merge_pipe.sv
`default_nettype none
//==============================================================================
// Module   : action_merge_pipe
// Brief    : Merges N sub-match actions (OR or priority), buffers them with
//            phv/vlan in a 2-entry skid FIFO and keeps hit/miss/conflict stats.
// Revision : 1.0 - initial release
//==============================================================================
module action_merge_pipe
   import action_merge_pipe_pkg::*;
#(
   parameter int NUM_SUB_UNIT   = 8,
   parameter int ACT_LEN        = 64,
   parameter int NUM_PHV_CONT   = 65,
   parameter int PHV_LEN        = 32*64+256,
   parameter int C_VLANID_WIDTH = 12,
   parameter int MERGE_MODE     = MERGE_OR,
   parameter int CNT_W          = 32
) (
   input  logic                                        axis_clk,
   input  logic                                        aresetn,
   input  logic                                        in_valid,
   output logic                                        ready_out,
   input  logic [NUM_SUB_UNIT-1:0]                     hit_in,
   input  logic [NUM_SUB_UNIT*ACT_LEN*NUM_PHV_CONT-1:0] action_in,
   input  logic [PHV_LEN-1:0]                          phv_in,
   input  logic [C_VLANID_WIDTH-1:0]                   vlan_in,
   output logic                                        out_valid,
   input  logic                                        ready_in,
   output logic [ACT_LEN*NUM_PHV_CONT-1:0]             action_out,
   output logic [PHV_LEN-1:0]                          phv_out,
   output logic [C_VLANID_WIDTH-1:0]                   vlan_out,
   output logic                                        hit_any_out,
   input  logic                                        cnt_clear,
   output logic [CNT_W-1:0]                            hit_cnt,
   output logic [CNT_W-1:0]                            miss_cnt,
   output logic [CNT_W-1:0]                            conflict_cnt
);

   localparam int              C_AW      = ACT_LEN * NUM_PHV_CONT;
   localparam int              C_FW      = C_AW + PHV_LEN + C_VLANID_WIDTH + 1;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   logic [C_AW-1:0]  w_masked [NUM_SUB_UNIT];
   logic [C_AW-1:0]  w_merged;
   logic             w_hit_any;
   logic             w_conflict;
   logic             w_push;
   logic [C_FW-1:0]  w_fifo_in;
   logic [C_FW-1:0]  w_fifo_out;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [CNT_W-1:0] r_conflict_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SUB_UNIT; gi++) begin : g_unit
         assign w_masked[gi] = hit_in[gi] ? action_in[act_lsb(gi, C_AW) +: C_AW] : '0;
      end

      if (MERGE_MODE == MERGE_PRIO) begin : g_mode_prio
         // scan from the top so the lowest-index hit is written last
         always_comb begin
            w_merged = '0;
            for (int i = NUM_SUB_UNIT - 1; i >= 0; i--) begin
               if (hit_in[i]) begin
                  w_merged = w_masked[i];
               end
            end
         end
      end else begin : g_mode_or
         always_comb begin
            w_merged = '0;
            for (int i = 0; i < NUM_SUB_UNIT; i++) begin
               w_merged = w_merged | w_masked[i];
            end
         end
      end
   endgenerate

   // a second hit is a conflict once any earlier unit has been seen
   always_comb begin
      w_hit_any  = 1'b0;
      w_conflict = 1'b0;
      for (int i = 0; i < NUM_SUB_UNIT; i++) begin
         w_conflict = w_conflict | (w_hit_any & hit_in[i]);
         w_hit_any  = w_hit_any | hit_in[i];
      end
   end

   assign w_push    = in_valid & ready_out;
   assign w_fifo_in = {w_merged, phv_in, vlan_in, w_hit_any};

   action_merge_pipe_skid_fifo2 #(
      .WIDTH (C_FW)
   ) u_skid (
      .axis_clk  (axis_clk),
      .aresetn   (aresetn),
      .in_valid  (in_valid),
      .in_ready  (ready_out),
      .in_data   (w_fifo_in),
      .out_valid (out_valid),
      .out_ready (ready_in),
      .out_data  (w_fifo_out)
   );

   assign {action_out, phv_out, vlan_out, hit_any_out} = w_fifo_out;

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_hit_cnt      <= '0;
         r_miss_cnt     <= '0;
         r_conflict_cnt <= '0;
      end else if (cnt_clear) begin
         r_hit_cnt      <= '0;
         r_miss_cnt     <= '0;
         r_conflict_cnt <= '0;
      end else if (w_push) begin
         if (w_hit_any && (r_hit_cnt != C_CNT_MAX)) begin
            r_hit_cnt <= r_hit_cnt + C_CNT_ONE;
         end
         if (!w_hit_any && (r_miss_cnt != C_CNT_MAX)) begin
            r_miss_cnt <= r_miss_cnt + C_CNT_ONE;
         end
         if (w_conflict && (r_conflict_cnt != C_CNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + C_CNT_ONE;
         end
      end
   end

   assign hit_cnt      = r_hit_cnt;
   assign miss_cnt     = r_miss_cnt;
   assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire
